// File: rtl/snake_body_engine_if.sv
// Bundles the game-side control, VGA pixel query and snake status signals of snake_body_engine.
// The master side is the game controller / timing generator, the slave side is the engine.
interface snake_body_engine_if #(
  parameter int MAX_LEN = 16
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic             tick;
  logic [2:0]       move;
  logic             start;
  logic             grow;
  logic [9:0]       x;
  logic [9:0]       y;
  logic             de;
  logic [4:0]       head_x;
  logic [4:0]       head_y;
  logic [LEN_W-1:0] length;
  logic             alive;
  logic             collide;
  logic             pix_head;
  logic             pix_body;

  modport master (
    output tick, move, start, grow, x, y, de,
    input  head_x, head_y, length, alive, collide, pix_head, pix_body
  );

  modport slave (
    input  tick, move, start, grow, x, y, de,
    output head_x, head_y, length, alive, collide, pix_head, pix_body
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake state engine: grid-cell body shift register, movement/growth/collision per tick,
// and a 2-stage pixel pipe that flags head/body cells for the colour mux.
module snake_body_engine #(
  parameter int MAX_LEN   = 16,
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int CELL      = 20,
  parameter int START_X   = 8,
  parameter int START_Y   = 12,
  parameter int START_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  snake_body_engine_if.slave bus
);

  localparam int                      LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]        LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]        LEN_START = LEN_W'(START_LEN);
  localparam logic signed [6:0]       GW        = 7'(GRID_W);
  localparam logic signed [6:0]       GH        = 7'(GRID_H);
  localparam logic [9:0]              CELL_PX   = 10'(CELL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } cell_t;

  function automatic cell_t init_cell(input int i);
    cell_t c;
    c.x = (i < START_LEN) ? 5'(START_X - i) : 5'd0;
    c.y = (i < START_LEN) ? 5'(START_Y)     : 5'd0;
    return c;
  endfunction

  state_t           state_q, state_n;
  dir_t             dir_q, dir_n;
  cell_t            seg [MAX_LEN];
  logic [LEN_W-1:0] len_q;
  logic             grow_pend_q;
  logic             collide_q;

  logic             run_tick, pause, reload;
  logic             grow_eff, growing;
  logic signed [6:0] nx, ny;
  cell_t            next_c;
  logic             wall_hit, self_hit;
  logic             kill, step_ok;

  logic [9:0]       col1, row1;
  logic             de1;
  logic             head_hit, body_hit;
  logic             pix_head_q, pix_body_q;

  assign run_tick = (state_q == S_RUN) && bus.tick;
  assign pause    = (bus.move == 3'b100);
  assign reload   = (state_q != S_RUN) && bus.start;
  assign grow_eff = grow_pend_q || bus.grow;
  // At full length a pending grow is consumed without extending, so the tail still vacates.
  assign growing  = grow_eff && (len_q != LEN_MAX);

  // ---------------------------------------------------------------------------
  // Direction and next head cell
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    dir_n = dir_q;
    if (!bus.move[2] && (bus.move[1:0] != (dir_q ^ 2'b10)))
      dir_n = dir_t'(bus.move[1:0]);
  end

  always_comb begin
    nx = signed'({2'b00, seg[0].x});
    ny = signed'({2'b00, seg[0].y});
    unique case (dir_n)
      DIR_RIGHT: nx = nx + 7'sd1;
      DIR_UP:    ny = ny - 7'sd1;
      DIR_LEFT:  nx = nx - 7'sd1;
      DIR_DOWN:  ny = ny + 7'sd1;
    endcase
    next_c.x = nx[4:0];
    next_c.y = ny[4:0];
  end

  assign wall_hit = (nx < 7'sd0) || (nx >= GW) || (ny < 7'sd0) || (ny >= GH);

  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_q) && (seg[i] == next_c) &&
          !((LEN_W'(i) == len_q - LEN_W'(1)) && !growing))
        self_hit = 1'b1;
    end
  end

  assign kill    = run_tick && !pause && (wall_hit || self_hit);
  assign step_ok = run_tick && !pause && !wall_hit && !self_hit;

  // ---------------------------------------------------------------------------
  // Game FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_n = S_RUN;
      S_RUN:   if (kill)      state_n = S_DEAD;
      S_DEAD:  if (bus.start) state_n = S_RUN;
      default:                state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.alive = (state_q == S_RUN);
  end

  // ---------------------------------------------------------------------------
  // Segment store, length, direction, pending growth
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the segment array is reset because the reset geometry is architecturally visible.
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_cell(i);
      len_q       <= LEN_START;
      dir_q       <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
    end else if (reload) begin
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_cell(i);
      len_q       <= LEN_START;
      dir_q       <= DIR_RIGHT;
      grow_pend_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      if (run_tick && !pause) dir_q <= dir_n;
      if (step_ok) begin
        for (int i = MAX_LEN - 1; i > 0; i--) seg[i] <= seg[i-1];
        seg[0] <= next_c;
        if (growing) len_q <= len_q + LEN_W'(1);
        grow_pend_q <= 1'b0;
      end else if (bus.grow) begin
        grow_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collide_q <= 1'b0;
    else        collide_q <= kill;
  end

  // ---------------------------------------------------------------------------
  // Pixel pipe: S1 converts pixel to cell, S2 compares against live segments
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col1 <= '0;
      row1 <= '0;
      de1  <= 1'b0;
    end else begin
      col1 <= bus.x / CELL_PX;
      row1 <= bus.y / CELL_PX;
      de1  <= bus.de;
    end
  end

  assign head_hit = (col1 == {5'd0, seg[0].x}) && (row1 == {5'd0, seg[0].y});

  always_comb begin
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_q) && (col1 == {5'd0, seg[i].x}) && (row1 == {5'd0, seg[i].y}))
        body_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_head_q <= 1'b0;
      pix_body_q <= 1'b0;
    end else begin
      pix_head_q <= de1 && head_hit;
      pix_body_q <= de1 && body_hit;
    end
  end

  assign bus.head_x   = seg[0].x;
  assign bus.head_y   = seg[0].y;
  assign bus.length   = len_q;
  assign bus.collide  = collide_q;
  assign bus.pix_head = pix_head_q;
  assign bus.pix_body = pix_body_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed game scenarios followed by randomized play, all
// compared each cycle against a queue-based snake model.
module tb_snake_body_engine;

  localparam int MAX_LEN = 16;
  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int CELL    = 20;

  logic clk;
  logic rst_n;

  snake_body_engine_if #(.MAX_LEN(MAX_LEN)) bus ();

  snake_body_engine #(
    .MAX_LEN(MAX_LEN), .GRID_W(GRID_W), .GRID_H(GRID_H), .CELL(CELL),
    .START_X(8), .START_Y(12), .START_LEN(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: snake as a queue of cells, head first ----------------
  int qx[$], qy[$];
  int m_dir, m_state, m_gp, m_collide;
  int m_c1, m_r1, m_de1, m_ph, m_pb;

  function automatic void m_init();
    qx = {}; qy = {};
    for (int i = 0; i < 3; i++) begin
      qx.push_back(8 - i);
      qy.push_back(12);
    end
    m_dir = 0;
    m_gp  = 0;
  endfunction

  function automatic void m_reset();
    m_init();
    m_state = 0; m_collide = 0;
    m_c1 = 0; m_r1 = 0; m_de1 = 0; m_ph = 0; m_pb = 0;
  endfunction

  function automatic void m_edge(input bit st, input bit tk, input int mv, input bit gr,
                                 input int px, input int py, input bit pde);
    int nh, nb, gp, nx, ny, grows, hit;
    nh = m_de1 && (m_c1 == qx[0]) && (m_r1 == qy[0]);
    nb = 0;
    for (int i = 1; i < qx.size(); i++)
      if (m_c1 == qx[i] && m_r1 == qy[i]) nb = 1;
    m_ph = nh;
    m_pb = m_de1 && nb;
    m_c1 = px / CELL; m_r1 = py / CELL; m_de1 = pde;
    m_collide = 0;
    if (m_state != 1) begin
      if (st) begin m_init(); m_state = 1; end
    end else begin
      gp = m_gp || gr;
      if (tk && mv != 4) begin
        if (mv < 4 && mv != (m_dir ^ 2)) m_dir = mv;
        nx = qx[0]; ny = qy[0];
        case (m_dir)
          0: nx++;
          1: ny--;
          2: nx--;
          default: ny++;
        endcase
        grows = gp && (qx.size() < MAX_LEN);
        hit = (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H);
        for (int i = 1; i < qx.size(); i++) begin
          if (i == qx.size() - 1 && !grows) continue;
          if (qx[i] == nx && qy[i] == ny) hit = 1;
        end
        if (hit) begin
          m_state = 2; m_collide = 1; m_gp = gp;
        end else begin
          qx.push_front(nx); qy.push_front(ny);
          if (!grows) begin void'(qx.pop_back()); void'(qy.pop_back()); end
          m_gp = 0;
        end
      end else begin
        m_gp = gp;
      end
    end
  endfunction

  task automatic compare_all();
    check("head_x",   bus.head_x,   qx[0]);
    check("head_y",   bus.head_y,   qy[0]);
    check("length",   bus.length,   qx.size());
    check("alive",    bus.alive,    m_state == 1);
    check("collide",  bus.collide,  m_collide);
    check("pix_head", bus.pix_head, m_ph);
    check("pix_body", bus.pix_body, m_pb);
  endtask

  // One clock: inputs driven at the negedge, model stepped at the posedge, outputs checked at the next negedge.
  task automatic step(input bit st, input bit tk, input int mv, input bit gr,
                      input int px, input int py, input bit pde);
    bus.start = st; bus.tick = tk; bus.move = 3'(mv); bus.grow = gr;
    bus.x = 10'(px); bus.y = 10'(py); bus.de = pde;
    @(posedge clk);
    m_edge(st, tk, mv, gr, px, py, pde);
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick(input int mv, input bit gr);
    step(1'b0, 1'b1, mv, gr, 0, 0, 1'b0);
  endtask

  task automatic start_game();
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic die();
    for (int k = 0; k < 64 && m_state == 1; k++) tick(m_dir, 1'b0);
    check("die_bound", bus.alive, 0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.tick = 0; bus.move = 0; bus.grow = 0; bus.x = 0; bus.y = 0; bus.de = 0;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sel, px, py;
    n_cmp = 0; n_bad = 0;
    m_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.tick = 0; bus.move = 0; bus.grow = 0; bus.x = 0; bus.y = 0; bus.de = 0;
    @(negedge clk); @(negedge clk);
    compare_all();
    check("rst_head_x", bus.head_x, 8);
    check("rst_length", bus.length, 3);
    rst_n = 1'b1;

    // start and move right four cells
    start_game();
    repeat (4) tick(0, 1'b0);
    check("t1_head_x", bus.head_x, 12);
    check("t1_head_y", bus.head_y, 12);
    check("t1_alive",  bus.alive,  1);

    // reversal ignored
    tick(2, 1'b0);
    check("t2_head_x", bus.head_x, 13);

    // grow on the same tick
    tick(0, 1'b1);
    check("t3_length", bus.length, 4);

    // run into the right wall
    for (int k = 0; k < 40 && qx[0] < 31; k++) tick(0, 1'b0);
    check("t4_at_edge", bus.head_x, 31);
    tick(0, 1'b0);
    check("t4_collide", bus.collide, 1);
    check("t4_alive",   bus.alive,   0);
    check("t4_head",    bus.head_x,  31);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t4_pulse",   bus.collide, 0);
    start_game();
    check("t4_restart_x", bus.head_x, 8);
    check("t4_restart_y", bus.head_y, 12);

    // pixel pipe latency on the head cell
    step(0, 0, 0, 0, 170, 250, 1);
    check("t6_lat1", bus.pix_head, 0);
    step(0, 0, 0, 0, 170, 250, 1);
    check("t6_lat2", bus.pix_head, 1);
    check("t6_body", bus.pix_body, 0);
    step(0, 0, 0, 0, 170, 250, 0);
    step(0, 0, 0, 0, 170, 250, 0);
    check("t6_de0", bus.pix_head, 0);

    // length 5 curl hits itself
    die(); start_game();
    tick(0, 1'b1); tick(0, 1'b1);
    tick(3, 1'b0); tick(2, 1'b0); tick(1, 1'b0);
    check("t5_curl_collide", bus.collide, 1);

    // length 4 tail chase survives
    start_game();
    tick(0, 1'b1);
    tick(3, 1'b0); tick(2, 1'b0); tick(1, 1'b0);
    check("t5_chase_alive", bus.alive, 1);

    // pause holds position and a pending grow
    tick(4, 1'b1);
    check("pause_len", bus.length, 4);
    tick(1, 1'b0);
    check("pause_grow", bus.length, 5);

    // saturation at MAX_LEN
    die(); start_game();
    repeat (15) tick(0, 1'b1);
    check("sat_len", bus.length, MAX_LEN);

    // randomized play
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) async_reset();
      sel = $urandom_range(0, 3);
      if (sel < 2) begin
        int idx;
        idx = $urandom_range(0, qx.size() - 1);
        px = qx[idx] * CELL + $urandom_range(0, CELL - 1);
        py = qy[idx] * CELL + $urandom_range(0, CELL - 1);
      end else begin
        px = $urandom_range(0, 799);
        py = $urandom_range(0, 524);
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7),
           $urandom_range(0, 9) == 0, px, py, $urandom_range(0, 7) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
